multiplier_ctrl: RTL

MULTIPLIER_CTRL -- requirements
Module: multiplier_ctrl

---
 rtl/multiplier_pkg.sv | 35 +++
 rtl/multiplier_ctrl.sv | 115 +++++++++++
 2 files changed

// File: rtl/multiplier_pkg.sv
// Shared encodings for the RV32M multiplier controller: FSM states, funct3 codes,
// and the partial-product alignment codes that the datapath decodes.
package multiplier_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_MUL   = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  // Alignment codes are Gray-ordered so only one datapath select bit toggles per pass.
  localparam logic [1:0] SFT_P0 = 2'b00;
  localparam logic [1:0] SFT_P1 = 2'b01;
  localparam logic [1:0] SFT_P2 = 2'b11;
  localparam logic [1:0] SFT_P3 = 2'b10;

  function automatic logic [1:0] pass_shift(input logic [1:0] cnt);
    logic [1:0] code;
    code = SFT_P0;
    case (cnt)
      2'd0:    code = SFT_P0;
      2'd1:    code = SFT_P1;
      2'd2:    code = SFT_P2;
      default: code = SFT_P3;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/multiplier_ctrl.sv
// Sequencer for a byte-serial RV32M multiplier datapath (MUL/MULH/MULHSU/MULHU).
// Latency: 6 cycles accept->valid_o; one operation per 7 cycles with ready_i held high.
// Backpressure: ready_o only in IDLE; valid_o holds in DONE until ready_i; flush_i aborts.
module multiplier_ctrl
  import multiplier_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       valid_i,
  input  logic [2:0] funct3_i,
  output logic       ready_o,
  input  logic       flush_i,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       reg_A_en_o,
  output logic       reg_B_en_o,
  output logic       AC_en_o,
  output logic       en_pipe_o,
  output logic       mux_B_sel_o,
  output logic       rol_en_o,
  output logic       signed_A_o,
  output logic       signed_B_o,
  output logic       upper_o,
  output logic [1:0] shift_amount_o,
  output logic       ac_clr_o
);

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       accept;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset is folded into the handshake so nothing is requested while rst_ni is low.
  assign accept = (state_q == ST_IDLE) & rst_ni & valid_i & ~funct3_i[2] & ~flush_i;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    ready_o        = 1'b0;
    valid_o        = 1'b0;
    reg_A_en_o     = 1'b0;
    reg_B_en_o     = 1'b0;
    AC_en_o        = 1'b0;
    en_pipe_o      = 1'b0;
    mux_B_sel_o    = 1'b0;
    rol_en_o       = 1'b0;
    signed_A_o     = 1'b0;
    signed_B_o     = 1'b0;
    upper_o        = 1'b0;
    shift_amount_o = SFT_P0;
    ac_clr_o       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ready_o = rst_ni;
        cnt_d   = 2'd0;
        if (accept) begin
          reg_A_en_o = 1'b1;
          reg_B_en_o = 1'b1;
          ac_clr_o   = 1'b1;
          signed_A_o = (funct3_i == F3_MULH) || (funct3_i == F3_MULHSU);
          signed_B_o = (funct3_i == F3_MULH);
          upper_o    = (funct3_i != F3_MUL);
          state_d    = ST_MUL;
        end
      end

      ST_MUL: begin
        en_pipe_o      = 1'b1;
        AC_en_o        = 1'b1;
        shift_amount_o = pass_shift(cnt_q);
        // B is rotated so the next byte lines up for the following pass; the last pass needs no rotate.
        if (cnt_q != 2'd3) begin
          reg_B_en_o  = 1'b1;
          mux_B_sel_o = 1'b1;
          rol_en_o    = 1'b1;
        end
        if (flush_i) begin
          state_d = ST_IDLE;
          cnt_d   = 2'd0;
        end else if (cnt_q == 2'd3) begin
          state_d = ST_DRAIN;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end

      ST_DRAIN: begin
        en_pipe_o = 1'b1;
        state_d   = flush_i ? ST_IDLE : ST_DONE;
      end

      ST_DONE: begin
        valid_o = ~flush_i;
        if (flush_i || ready_i) state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

endmodule
